// File: rtl/mc_controller_pkg.sv
// mips_defs: shared definitions for the multi-cycle main controller.
// Holds opcode/funct constants, the FSM state encoding, the encodings of
// every datapath select, and the one-hot instruction class record that the
// decoder hands to the FSM.
package mips_defs;

  // Primary opcodes (Instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (Instr[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // FSM states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // PCSrc
  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  // RegDst
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // MemtoReg
  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_DM  = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // ALUOp
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  // ExtOp
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  // One-hot instruction class; exactly one bit is set for any ir value.
  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } instr_class_t;

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: bundle between the controller and the fetch unit /
// datapath.
//   Instr, zero          : datapath -> controller (instruction word, ALU eq flag)
//   PCSrc, PCWr          : controller -> fetch unit (next-PC select, PC write)
//   IRWr, RegWr, MemWr   : write strobes, one cycle each
//   RegDst, MemtoReg,
//   ALUSrc, ALUOp, ExtOp : datapath selects, stable for a whole instruction
//   state                : current FSM state, for debug
// There is no valid/ready handshake: the controller paces the datapath, and
// a strobe being high for a cycle is the whole transaction (the datapath acts
// on the rising edge that ends that cycle).
interface mc_controller_if;
  logic [31:0] Instr;
  logic        zero;
  logic [1:0]  PCSrc;
  logic        PCWr;
  logic        IRWr;
  logic        RegWr;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic        ALUSrc;
  logic [2:0]  ALUOp;
  logic [1:0]  ExtOp;
  logic        MemWr;
  logic [2:0]  state;

  modport master (
    input  Instr, zero,
    output PCSrc, PCWr, IRWr, RegWr, RegDst, MemtoReg,
           ALUSrc, ALUOp, ExtOp, MemWr, state
  );

  modport slave (
    output Instr, zero,
    input  PCSrc, PCWr, IRWr, RegWr, RegDst, MemtoReg,
           ALUSrc, ALUOp, ExtOp, MemWr, state
  );
endinterface

// File: rtl/mc_controller_decoder.sv
// mc_decoder: combinational instruction classifier.
//   op_i    : ir[31:26]
//   funct_i : ir[5:0]
//   cls_o   : one-hot instruction class (unrecognised encodings -> nop)
//   sub_o   : within rtype_alu, selects subu over addu
module mc_decoder
  import mips_defs::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   funct_i,
  output instr_class_t cls_o,
  output logic         sub_o
);

  always_comb begin
    cls_o = '0;
    sub_o = 1'b0;
    case (op_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADDU) begin
          cls_o.rtype_alu = 1'b1;
        end else if (funct_i == FN_SUBU) begin
          cls_o.rtype_alu = 1'b1;
          sub_o           = 1'b1;
        end else if (funct_i == FN_JR) begin
          cls_o.jr = 1'b1;
        end else begin
          cls_o.nop = 1'b1;
        end
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: cls_o.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle main controller.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mc_controller_if.master (Instr/zero in; PC control, strobes,
//           datapath selects and debug state out)
// Only state_q and ir_q are registers; every output is decoded from
// (state_q, ir_q, zero). PCWr fires once per instruction, in its last state.
module mc_controller
  import mips_defs::*;
(
  input  logic           clk,
  input  logic           reset,
  mc_controller_if.master bus
);

  state_t       state_q;
  logic [31:0]  ir_q;
  instr_class_t cls;
  logic         alu_sub;

  // Register/immediate fields are taken by the datapath directly; the
  // controller only looks at op and funct.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir_q[25:6];

  mc_decoder u_decoder (
    .op_i    (ir_q[31:26]),
    .funct_i (ir_q[5:0]),
    .cls_o   (cls),
    .sub_o   (alu_sub)
  );

  // Instruction sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= bus.Instr;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (cls.j || cls.jal || cls.jr || cls.nop) state_q <= S_FETCH;
          else                                       state_q <= S_EXE;
        end
        S_EXE: begin
          if (cls.beq)             state_q <= S_FETCH;
          else if (cls.lw || cls.sw) state_q <= S_MEM;
          else                     state_q <= S_WB;
        end
        S_MEM: begin
          if (cls.sw) state_q <= S_FETCH;
          else        state_q <= S_WB;
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  logic [1:0] pc_src;
  logic       pc_wr, ir_wr, reg_wr, mem_wr;
  logic [1:0] reg_dst, mem_to_reg, ext_op;
  logic       alu_src;
  logic [2:0] alu_op;

  always_comb begin
    pc_src     = PCSRC_PC4;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALU;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = EXT_ZERO;

    // Selects follow ir from DECODE onward; in FETCH ir may still hold the
    // previous instruction, so they are held at zero there.
    if (state_q != S_FETCH) begin
      if (cls.rtype_alu) begin
        reg_dst = REGDST_RD;
        alu_op  = alu_sub ? ALU_SUB : ALU_ADD;
      end
      if (cls.ori) begin
        ext_op  = EXT_ZERO;
        alu_src = 1'b1;
        alu_op  = ALU_OR;
      end
      if (cls.lui) begin
        alu_src = 1'b1;
        alu_op  = ALU_LUI;
      end
      if (cls.lw || cls.sw) begin
        ext_op  = EXT_SIGN;
        alu_src = 1'b1;
        alu_op  = ALU_ADD;
      end
      if (cls.lw) mem_to_reg = M2R_DM;
      if (cls.beq) alu_op = ALU_SUB;
      if (cls.jal) begin
        reg_dst    = REGDST_RA;
        mem_to_reg = M2R_PC4;
      end
    end

    case (state_q)
      S_FETCH: ir_wr = 1'b1;
      S_DECODE: begin
        if (cls.j || cls.jal) begin
          pc_wr  = 1'b1;
          pc_src = PCSRC_J;
        end
        if (cls.jal) reg_wr = 1'b1;
        if (cls.jr) begin
          pc_wr  = 1'b1;
          pc_src = PCSRC_JR;
        end
        if (cls.nop) pc_wr = 1'b1;
      end
      S_EXE: begin
        if (cls.beq) begin
          pc_wr  = 1'b1;
          pc_src = bus.zero ? PCSRC_BR : PCSRC_PC4;
        end
      end
      S_MEM: begin
        if (cls.sw) begin
          mem_wr = 1'b1;
          pc_wr  = 1'b1;
        end
      end
      S_WB: begin
        reg_wr = 1'b1;
        pc_wr  = 1'b1;
      end
      default: ;
    endcase

    // A reset cycle abandons the instruction: nothing may be written.
    if (reset) begin
      pc_wr  = 1'b0;
      ir_wr  = 1'b0;
      reg_wr = 1'b0;
      mem_wr = 1'b0;
    end
  end

  assign bus.PCSrc    = pc_src;
  assign bus.PCWr     = pc_wr;
  assign bus.IRWr     = ir_wr;
  assign bus.RegWr    = reg_wr;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.ALUSrc   = alu_src;
  assign bus.ALUOp    = alu_op;
  assign bus.ExtOp    = ext_op;
  assign bus.MemWr    = mem_wr;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized check of mc_controller against a
// cycle-indexed reference model of each instruction's output sequence.
module tb_mc_controller;

  localparam int W = 19;

  typedef enum {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ,
                K_J, K_JAL, K_JR, K_NOP} kind_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {bus.state, bus.PCSrc, bus.PCWr, bus.IRWr, bus.RegWr, bus.RegDst,
            bus.MemtoReg, bus.ALUSrc, bus.ALUOp, bus.ExtOp, bus.MemWr};
  endfunction

  function automatic logic [3:0] observed_strobes();
    return {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr};
  endfunction

  function automatic logic [W-1:0] pack(
    input logic [2:0] st, input logic [1:0] ps, input logic pw, input logic iw,
    input logic rw, input logic [1:0] rd, input logic [1:0] m2r, input logic as,
    input logic [2:0] ao, input logic [1:0] eo, input logic mw);
    return {st, ps, pw, iw, rw, rd, m2r, as, ao, eo, mw};
  endfunction

  // ---------------- reference model ----------------
  function automatic kind_t classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h08) return K_JR;
      return K_NOP;
    end
    case (op)
      6'h0d:   return K_ORI;
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h04:   return K_BEQ;
      6'h0f:   return K_LUI;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  // Pushes one expected output vector per cycle of the instruction.
  // z is the zero flag seen in the beq EXE cycle.
  function automatic void build(input logic [31:0] w, input logic z);
    kind_t k;
    int n;
    int seq[5];
    logic [1:0] rd, m2r, eo, lps;
    logic as, wr;
    logic [2:0] ao;
    k = classify(w);
    rd = 0; m2r = 0; eo = 0; as = 0; ao = 0; lps = 0;
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: begin n = 4; seq = '{0, 1, 2, 4, 0}; end
      K_LW:  begin n = 5; seq = '{0, 1, 2, 3, 4}; end
      K_SW:  begin n = 4; seq = '{0, 1, 2, 3, 0}; end
      K_BEQ: begin n = 3; seq = '{0, 1, 2, 0, 0}; end
      default: begin n = 2; seq = '{0, 1, 0, 0, 0}; end
    endcase
    case (k)
      K_ADDU: rd = 2'b01;
      K_SUBU: begin rd = 2'b01; ao = 3'b001; end
      K_ORI:  begin as = 1; ao = 3'b010; eo = 2'b00; end
      K_LUI:  begin as = 1; ao = 3'b011; end
      K_LW:   begin as = 1; eo = 2'b01; m2r = 2'b01; end
      K_SW:   begin as = 1; eo = 2'b01; end
      K_BEQ:  ao = 3'b001;
      K_JAL:  begin rd = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    wr = (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_JAL});
    case (k)
      K_J, K_JAL: lps = 2'b10;
      K_JR:       lps = 2'b11;
      K_BEQ:      lps = z ? 2'b01 : 2'b00;
      default:    lps = 2'b00;
    endcase
    for (int c = 0; c < n; c++) begin
      logic last;
      last = (c == n - 1);
      if (c == 0)
        exp_q.push_back(pack(3'd0, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 3'b000, 2'b00, 0));
      else
        exp_q.push_back(pack(3'(seq[c]), last ? lps : 2'b00, last, 1'b0, last && wr,
                             rd, m2r, as, ao, eo, last && (k == K_SW)));
    end
  endfunction

  function automatic logic [31:0] make_word(input kind_t k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADDU: return {6'h00, r[25:6], 6'h21};
      K_SUBU: return {6'h00, r[25:6], 6'h23};
      K_JR:   return {6'h00, r[25:6], 6'h08};
      K_ORI:  return {6'h0d, r[25:0]};
      K_LW:   return {6'h23, r[25:0]};
      K_SW:   return {6'h2b, r[25:0]};
      K_BEQ:  return {6'h04, r[25:0]};
      K_LUI:  return {6'h0f, r[25:0]};
      K_J:    return {6'h02, r[25:0]};
      K_JAL:  return {6'h03, r[25:0]};
      default: begin
        case (r[31:30])
          2'd0:    return 32'h0;
          2'd1:    return {6'h3f, r[25:0]};
          default: return {6'h00, r[25:6], 6'h2a};
        endcase
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT in FETCH.
  // garble: drive junk on Instr after FETCH (controls must follow ir).
  // zmode: -1 random zero per cycle, else zero held at that value.
  // abort_at: cycle index at which reset is asserted (-1 = never).
  task automatic run_instr(input logic [31:0] w, input bit garble,
                           input int zmode, input int abort_at);
    logic zarr[5];
    logic [W-1:0] e;
    int n;
    for (int c = 0; c < 5; c++)
      zarr[c] = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    exp_q.delete();
    build(w, zarr[2]);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      bus.Instr = (k == 0 || !garble) ? w : $urandom;
      bus.zero  = zarr[k];
      e = exp_q.pop_front();
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check($sformatf("rst_strobes w=%08h cyc%0d", w, k), 32'(observed_strobes()), 32'h0);
        check($sformatf("rst_state w=%08h cyc%0d", w, k), 32'(bus.state), 32'(e[W-1 -: 3]));
        @(posedge clk); #1;
        check($sformatf("post_rst_state w=%08h", w), 32'(bus.state), 32'h0);
        check($sformatf("post_rst_ir w=%08h", w), dut.ir_q, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
      check($sformatf("w=%08h cyc%0d", w, k), 32'(observed()), 32'(e));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    bus.Instr = 32'h0;
    bus.zero  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_strobes", 32'(observed_strobes()), 32'h0);
      @(posedge clk);
    end
    #1;
    reset = 1'b0;
    check("reset_state", 32'(bus.state), 32'h0);
    check("reset_ir", dut.ir_q, 32'h0);

    // Directed cases
    run_instr(32'h00000000, 1'b0, -1, -1);
    run_instr(32'h00221821, 1'b1, -1, -1);  // addu $3,$1,$2
    run_instr(32'h8c220004, 1'b1, -1, -1);  // lw $2,4($1)
    run_instr(32'h1022ffff, 1'b0,  1, -1);  // beq taken
    run_instr(32'h1022ffff, 1'b0,  0, -1);  // beq not taken
    run_instr(32'h0c000c00, 1'b1, -1, -1);  // jal 0x0C00
    run_instr(32'hac220008, 1'b0, -1,  3);  // sw, reset during MEM
    run_instr(32'hac220008, 1'b0, -1, -1);  // sw completes
    run_instr(32'h00000008 | 32'h03e00000, 1'b1, -1, -1);  // jr $31

    // Random mix with occasional mid-instruction reset
    for (int i = 0; i < 400; i++) begin
      kind_t k;
      int ab;
      k  = kind_t'($urandom_range(0, 10));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(make_word(k), 1'($urandom_range(0, 1)), -1, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
